// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Credit-based issue controller for a registered 32-bit ALU with an
//            in-order result FIFO. Optional macro: ALU_DIV0_FLAG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl #(
  parameter int RES_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [3:0]       cmd_op,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [3:0]       alu_sel,
  input  logic [63:0]      alu_out,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [63:0]      res_data,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_err
);

  localparam int c_ptr_w = $clog2(RES_DEPTH);
  localparam logic [c_ptr_w:0]   c_depth_cnt = (c_ptr_w+1)'(RES_DEPTH);
  localparam logic [c_ptr_w+1:0] c_depth_ext = (c_ptr_w+2)'(RES_DEPTH);

  logic [31:0]        r_alu_a;
  logic [31:0]        r_alu_b;
  logic [3:0]         r_alu_sel;
  logic [1:0]         r_vld;
  logic [TAG_W-1:0]   r_tag0;
  logic [TAG_W-1:0]   r_tag1;
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic [63:0]        r_mem_data [RES_DEPTH];
  logic [TAG_W-1:0]   r_mem_tag  [RES_DEPTH];

  logic               w_accept;
  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w+1:0] w_used;
  logic [63:0]        w_push_data;

  // Credits cover buffered entries plus everything still in the ALU pipe.
  assign w_used    = {1'b0, r_count} + (c_ptr_w+2)'(r_vld[0]) + (c_ptr_w+2)'(r_vld[1]);
  assign cmd_ready = ~rst & (w_used < c_depth_ext);
  assign w_accept  = cmd_valid & cmd_ready;
  assign w_push    = r_vld[1];
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid & res_ready;

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_sel  = r_alu_sel;
  assign res_data = res_valid ? r_mem_data[r_rd_ptr] : 64'h0;
  assign res_tag  = res_valid ? r_mem_tag[r_rd_ptr]  : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= '0;
      r_vld     <= '0;
      r_tag0    <= '0;
      r_tag1    <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
    end else begin
      r_vld  <= {r_vld[0], w_accept};
      r_tag1 <= r_tag0;
      if (w_accept) begin
        r_alu_a   <= cmd_a;
        r_alu_b   <= cmd_b;
        r_alu_sel <= cmd_op;
        r_tag0    <= cmd_tag;
      end
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= w_push_data;
      r_mem_tag[r_wr_ptr]  <= r_tag1;
    end
  end

`ifdef ALU_DIV0_FLAG_EN
  logic [1:0] r_div0;
  logic       r_mem_err [RES_DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div0 <= '0;
    end else begin
      r_div0[1] <= r_div0[0];
      if (w_accept) r_div0[0] <= (cmd_op == 4'b0011) && (cmd_b == 32'h0);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem_err[r_wr_ptr] <= r_div0[1];
  end

  assign w_push_data = r_div0[1] ? 64'h0 : alu_out;
  assign res_err     = res_valid & r_mem_err[r_rd_ptr];
`else
  assign w_push_data = alu_out;
  assign res_err     = 1'b0;
`endif

  // Credit scheme must make these unreachable.
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(w_pop && (r_count == '0)));
      assert (!(w_push && !w_pop && (r_count == c_depth_cnt)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// Directed bench for alu_issue_ctrl with a registered mock ALU and an
// in-order scoreboard of expected results.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic [3:0]  cmd_op;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_sel;
  logic [63:0] alu_out;
  logic        res_valid, res_ready;
  logic [63:0] res_data;
  logic [3:0]  res_tag;
  logic        res_err;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.RES_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_tag(res_tag), .res_err(res_err)
  );

  function automatic logic [63:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] op);
    case (op)
      4'b0000: alu_f = {32'h0, a} + {32'h0, b};
      4'b0010: alu_f = {32'h0, a} * {32'h0, b};
      4'b0011: alu_f = (b == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : {32'h0, a / b};
      4'b1111: alu_f = {a, b};
      default: alu_f = {32'h0, a ^ b};
    endcase
  endfunction

  // Registered mock ALU: one cycle from alu_a/alu_b/alu_sel to alu_out.
  always @(posedge clk) alu_out <= alu_f(alu_a, alu_b, alu_sel);

  typedef struct {
    logic [63:0] data;
    logic [3:0]  tag;
    logic        err;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_pass = 0, n_acc = 0, n_pop = 0;

  task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic [3:0] op, input logic [3:0] tag);
    exp_t e;
    e.data = alu_f(a, b, op);
    e.tag  = tag;
    e.err  = 1'b0;
`ifdef ALU_DIV0_FLAG_EN
    if (op == 4'b0011 && b == 0) begin
      e.data = 64'h0;
      e.err  = 1'b1;
    end
`endif
    return e;
  endfunction

  // Score what happens at the coming edge, then advance to edge + 1.
  task automatic tick();
    exp_t e;
    if (cmd_valid && cmd_ready) begin
      q.push_back(model(cmd_a, cmd_b, cmd_op, cmd_tag));
      n_acc++;
    end
    if (res_valid && res_ready) begin
      n_pop++;
      if (q.size() == 0) check_val("unexpected_result", 1, 0);
      else begin
        e = q.pop_front();
        check_val("res_data", res_data, e.data);
        check_val("res_tag", {60'h0, res_tag}, {60'h0, e.tag});
        check_val("res_err", {63'h0, res_err}, {63'h0, e.err});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [3:0] tag);
    cmd_valid = 1'b1;
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
  endtask

  task automatic drain(input int max_cycles);
    res_ready = 1'b1;
    for (int i = 0; i < max_cycles && q.size() > 0; i++) tick();
    check_val("drain_empty", q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc0, pop0, bad, hits;
    bit seen;
    logic [3:0] ops [5];
    ops = '{4'h0, 4'h2, 4'h3, 4'h5, 4'hF};

    rst = 1'b1; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; cmd_tag = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_cmd_ready", {63'h0, cmd_ready}, 0);
    check_val("rst_res_valid", {63'h0, res_valid}, 0);
    check_val("rst_res_data", res_data, 0);
    check_val("rst_res_tag", {60'h0, res_tag}, 0);
    check_val("rst_res_err", {63'h0, res_err}, 0);
    check_val("rst_alu_a", {32'h0, alu_a}, 0);
    check_val("rst_alu_b", {32'h0, alu_b}, 0);
    check_val("rst_alu_sel", {60'h0, alu_sel}, 0);
    rst = 1'b0;
    #1;
    check_val("ready_after_rst", {63'h0, cmd_ready}, 1);

    // Basic latency: 5 + 3, tag 1.
    drive(32'd5, 32'd3, 4'b0000, 4'd1);
    tick();
    cmd_valid = 1'b0;
    check_val("issue_alu_a", {32'h0, alu_a}, 5);
    check_val("issue_alu_b", {32'h0, alu_b}, 3);
    check_val("issue_alu_sel", {60'h0, alu_sel}, 0);
    tick();
    check_val("lat_not_yet", {63'h0, res_valid}, 0);
    check_val("hold_alu_a", {32'h0, alu_a}, 5);
    tick();
    check_val("lat_valid", {63'h0, res_valid}, 1);
    check_val("lat_data", res_data, 64'd8);
    check_val("lat_tag", {60'h0, res_tag}, 1);
    res_ready = 1'b1;
    tick();
    check_val("lat_popped", {63'h0, res_valid}, 0);

    // Back-pressure: fill all four credits.
    res_ready = 1'b0;
    acc0 = n_acc;
    for (int i = 0; i < 4; i++) begin
      drive(32'(i + 20), 32'd2, 4'b0000, 4'(i + 2));
      check_val("credit_ready", {63'h0, cmd_ready}, 1);
      tick();
    end
    check_val("full_backpressure", {63'h0, cmd_ready}, 0);
    drive(32'd100, 32'd1, 4'b0000, 4'd6);
    repeat (6) tick();
    check_val("full_no_accept", n_acc - acc0, 4);
    check_val("full_res_valid", {63'h0, res_valid}, 1);
    res_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (cmd_ready) seen = 1'b1;
      tick();
    end
    cmd_valid = 1'b0;
    check_val("ready_returns", {63'h0, seen}, 1);
    drain(20);

    // Streaming 16 multiplies with no bubbles.
    res_ready = 1'b1;
    pop0 = n_pop;
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      drive(32'(i), 32'(i + 1), 4'b0010, 4'(i));
      if (!cmd_ready) bad++;
      tick();
    end
    cmd_valid = 1'b0;
    repeat (3) tick();
    check_val("stream_ready", bad, 0);
    check_val("stream_results", n_pop - pop0, 16);
    drain(10);

    // Random consumer stalls with continuous offered commands.
    acc0 = n_acc;
    pop0 = n_pop;
    for (int k = 0; k < 80; k++) begin
      res_ready = ($urandom_range(0, 2) == 0);
      drive($urandom, 32'($urandom_range(0, 5)), ops[$urandom_range(0, 4)], 4'(k));
      tick();
    end
    cmd_valid = 1'b0;
    drain(40);
    check_val("rand_count", n_acc - acc0, n_pop - pop0);

    // Reset with two in flight and two buffered.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(32'(i + 40), 32'd1, 4'b0000, 4'(8 + i));
      tick();
    end
    cmd_valid = 1'b0;
    check_val("pre_rst_valid", {63'h0, res_valid}, 1);
    rst = 1'b1;
    #1;
    check_val("mid_rst_res_valid", {63'h0, res_valid}, 0);
    check_val("mid_rst_cmd_ready", {63'h0, cmd_ready}, 0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("post_rst_ready", {63'h0, cmd_ready}, 1);
    res_ready = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid) hits++;
      tick();
    end
    check_val("no_stale_results", hits, 0);

    // Opcode 4'b1111 issues normally.
    drive(32'hDEAD_BEEF, 32'h1234_5678, 4'hF, 4'd3);
    res_ready = 1'b0;
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    check_val("op15_data", res_data, 64'hDEAD_BEEF_1234_5678);
    drain(10);

    // Divide by zero.
    res_ready = 1'b0;
    drive(32'd10, 32'd0, 4'b0011, 4'd7);
    tick();
    cmd_valid = 1'b0;
    repeat (2) tick();
    check_val("div0_valid", {63'h0, res_valid}, 1);
    check_val("div0_tag", {60'h0, res_tag}, 7);
`ifdef ALU_DIV0_FLAG_EN
    check_val("div0_err", {63'h0, res_err}, 1);
    check_val("div0_data", res_data, 64'h0);
`else
    check_val("div0_err", {63'h0, res_err}, 0);
    check_val("div0_data", res_data, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
    drain(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
